// File: rtl/adventure_pkg.sv
// Shared definitions for the adventure-game player controller.
//   - Room codes, matching the room FSM's room_locate encoding.
//   - Direction codes, matching the room FSM's direction input.
//   - Controller state enum.
//   - neutral_dir(): a per-room direction that the room FSM treats as a no-op.
//   - is_end_room(): true for the two terminal rooms.
package adventure_pkg;

  localparam logic [2:0] ROOM_CAVE   = 3'b000;  // Cave of Cacophony (start)
  localparam logic [2:0] ROOM_TUNNEL = 3'b001;  // Twisty Tunnel
  localparam logic [2:0] ROOM_RIVER  = 3'b010;  // Rapid River
  localparam logic [2:0] ROOM_STASH  = 3'b011;  // Secret Sword Stash
  localparam logic [2:0] ROOM_DEN    = 3'b100;  // Dragon's Den
  localparam logic [2:0] ROOM_GRAVE  = 3'b101;  // Grievous Graveyard (lose)
  localparam logic [2:0] ROOM_WIN    = 3'b110;  // Victory Vault (win)

  typedef enum logic [1:0] {
    DIR_N = 2'b00,
    DIR_E = 2'b01,
    DIR_W = 2'b10,
    DIR_S = 2'b11
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRIVE,
    ST_CHECK,
    ST_DONE
  } ctrl_state_e;

  // Direction that leaves the given room unchanged in the room FSM.
  function automatic dir_e neutral_dir(input logic [2:0] room);
    case (room)
      ROOM_CAVE:   return DIR_W;
      ROOM_TUNNEL: return DIR_N;
      ROOM_RIVER:  return DIR_S;
      ROOM_STASH:  return DIR_N;
      default:     return DIR_N;
    endcase
  endfunction

  function automatic logic is_end_room(input logic [2:0] room);
    return (room == ROOM_GRAVE) || (room == ROOM_WIN);
  endfunction

endpackage

// File: rtl/adventure_btn_arbiter.sv
// Direction-button arbiter.
// Picks one direction from the four level requests with fixed priority
// N > E > S > W, and only offers it while armed. armed drops when a request
// is accepted (or on disarm) and comes back only once all buttons are seen
// released, so one press produces exactly one move.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   btn_req[3:0] : level requests [3]=N [2]=E [1]=S [0]=W
//   accept       : controller took the offered request this cycle
//   disarm       : controller forces armed low (new game / restart)
//   req_valid    : armed and at least one button held
//   req_dir      : highest-priority requested direction
module adventure_btn_arbiter
  import adventure_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_req,
  input  logic       accept,
  input  logic       disarm,
  output logic       req_valid,
  output dir_e       req_dir
);

  logic armed;

  // NOTE: sequential state is written only with non-blocking (<=) so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      armed <= 1'b0;
    end else if (accept || disarm) begin
      armed <= 1'b0;
    end else if (btn_req == 4'b0000) begin
      armed <= 1'b1;
    end
  end

  assign req_valid = armed && (btn_req != 4'b0000);

  // NOTE: req_dir gets a default before the priority chain; without it a
  // path with no assignment would infer a latch.
  always_comb begin
    req_dir = DIR_W;
    if (btn_req[3])      req_dir = DIR_N;
    else if (btn_req[2]) req_dir = DIR_E;
    else if (btn_req[1]) req_dir = DIR_S;
  end

endmodule

// File: rtl/adventure_game_ctrl.sv
// Player-side controller for the adventure-game room FSM.
// Turns button presses into single one-cycle move commands, holds a per-room
// no-op direction between moves, checks whether each move changed the room,
// tracks the sword, counts moves and reports end-of-game and den stalls.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   play          : level, game enabled
//   restart       : one-cycle pulse, leaves DONE
//   btn_req[3:0]  : button levels [3]=N [2]=E [1]=S [0]=W
//   room_locate   : current room from the room FSM
//   room_result   : win flag from the room FSM
//   direction     : move command to the room FSM (N=00 E=01 S=11 W=10)
//   room_start    : room FSM start (low holds it in the Cave)
//   room_reset    : room FSM reset (leaves Graveyard/Vault)
//   sword_state   : sword held, fed back to the room FSM
//   move_count    : saturating count of moves that changed room
//   illegal_move  : one-cycle pulse, accepted move left the room unchanged
//   game_over     : high in DONE
//   win           : result, valid while game_over is high
//   den_error     : sticky, too long in Dragon's Den
module adventure_game_ctrl
  import adventure_pkg::*;
#(
  parameter int MOVE_CNT_W  = 8,
  parameter int DEN_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  restart,
  input  logic [3:0]            btn_req,
  input  logic [2:0]            room_locate,
  input  logic                  room_result,
  output logic [1:0]            direction,
  output logic                  room_start,
  output logic                  room_reset,
  output logic                  sword_state,
  output logic [MOVE_CNT_W-1:0] move_count,
  output logic                  illegal_move,
  output logic                  game_over,
  output logic                  win,
  output logic                  den_error
);

  localparam int DEN_W = $clog2(DEN_TIMEOUT + 1);

  ctrl_state_e      state;
  dir_e             dir_q;
  logic [2:0]       room_q;
  logic [DEN_W-1:0] den_cnt;

  logic req_valid;
  dir_e req_dir;
  logic accept;
  logic disarm;

  // Same condition as the WAIT branch that latches a move.
  assign accept = (state == ST_WAIT) && play && !is_end_room(room_locate) && req_valid;
  assign disarm = ((state == ST_IDLE) && play) || ((state == ST_DONE) && restart);

  adventure_btn_arbiter u_arbiter (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_req   (btn_req),
    .accept    (accept),
    .disarm    (disarm),
    .req_valid (req_valid),
    .req_dir   (req_dir)
  );

  // Outside the one DRIVE cycle the room FSM sees a direction that cannot
  // move it, so it never takes a spurious step.
  assign direction = (state == ST_DRIVE) ? dir_q : neutral_dir(room_locate);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      dir_q        <= DIR_N;
      room_q       <= ROOM_CAVE;
      den_cnt      <= '0;
      room_start   <= 1'b0;
      room_reset   <= 1'b0;
      sword_state  <= 1'b0;
      move_count   <= '0;
      illegal_move <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
      den_error    <= 1'b0;
    end else begin
      illegal_move <= 1'b0;
      room_reset   <= 1'b0;

      // Consecutive cycles in the Den; any other room restarts the timer.
      if (room_locate == ROOM_DEN) begin
        if (den_cnt != DEN_W'(DEN_TIMEOUT)) den_cnt <= den_cnt + DEN_W'(1);
        if (den_cnt == DEN_W'(DEN_TIMEOUT - 1)) den_error <= 1'b1;
      end else begin
        den_cnt <= '0;
      end

      if (state != ST_IDLE && state != ST_DONE && room_locate == ROOM_STASH)
        sword_state <= 1'b1;

      case (state)
        ST_IDLE: begin
          room_start <= 1'b0;
          if (play) begin
            room_start  <= 1'b1;
            sword_state <= 1'b0;
            move_count  <= '0;
            den_error   <= 1'b0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!play) begin
            room_start <= 1'b0;
            state      <= ST_IDLE;
          end else if (is_end_room(room_locate)) begin
            game_over <= 1'b1;
            win       <= room_result;
            state     <= ST_DONE;
          end else if (req_valid) begin
            dir_q  <= req_dir;
            room_q <= room_locate;
            state  <= ST_DRIVE;
          end
        end
        ST_DRIVE: state <= ST_CHECK;
        ST_CHECK: begin
          // The room FSM has taken the move by now; compare against the
          // room we left from.
          if (room_locate != room_q) begin
            if (move_count != {MOVE_CNT_W{1'b1}}) move_count <= move_count + MOVE_CNT_W'(1);
          end else begin
            illegal_move <= 1'b1;
          end
          state <= ST_WAIT;
        end
        ST_DONE: begin
          win <= room_result;
          if (restart) begin
            room_reset  <= 1'b1;
            room_start  <= 1'b0;
            sword_state <= 1'b0;
            move_count  <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
